piso_serializer: RTL

- Parallel-in, serial-out transmitter; the sending end of the serial bit-stream consumed by the team's serial-in shift chains.
- Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clock, with frame-first and frame-last markers.
- A one-word holding buffer allows back-to-back frames with no idle cycles between them.
- Sits between a word producer (FSM or FIFO) and a serial link or shift chain.

---
 rtl/piso_serializer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with a one-word holding buffer for gapless frames.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

`ifdef PISO_PARITY_EN
  localparam int SW = WIDTH + 1;
`else
  localparam int SW = WIDTH;
`endif
  localparam int FRAME_LEN = SW;
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam int OUT_BIT   = (MSB_FIRST != 0) ? SW - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [SW-1:0]    sreg, sreg_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] hold_data, hold_data_n;
  logic             hold_full, hold_full_n;
  logic             accept;
  logic             last_bit;

  // Parity sits on the far side of the data so it leaves after the last data bit.
  function automatic logic [SW-1:0] load_word(input logic [WIDTH-1:0] w);
    logic [SW-1:0] v;
`ifdef PISO_PARITY_EN
    if (MSB_FIRST != 0) v = {w, ^w};
    else                v = {^w, w};
`else
    v = w;
`endif
    return v;
  endfunction

  function automatic logic [SW-1:0] shift_word(input logic [SW-1:0] s);
    logic [SW-1:0] v;
    if (MSB_FIRST != 0) v = {s[SW-2:0], 1'b0};
    else                v = {1'b0, s[SW-1:1]};
    return v;
  endfunction

  assign in_ready = !hold_full && !rst;
  assign accept   = in_valid && in_ready;
  assign last_bit = (state == SHIFT) && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_n;
      sreg      <= sreg_n;
      cnt       <= cnt_n;
      hold_data <= hold_data_n;
      hold_full <= hold_full_n;
    end
  end

  always_comb begin
    state_n     = state;
    sreg_n      = sreg;
    cnt_n       = cnt;
    hold_data_n = hold_data;
    hold_full_n = hold_full;
    case (state)
      IDLE: begin
        if (accept) begin
          sreg_n  = load_word(in_data);
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          // A held word always wins; in_ready is low while one is held.
          cnt_n = '0;
          if (hold_full) begin
            sreg_n      = load_word(hold_data);
            hold_full_n = 1'b0;
          end else if (accept) begin
            sreg_n = load_word(in_data);
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n  = cnt + CNT_W'(1);
          sreg_n = shift_word(sreg);
          if (accept) begin
            hold_data_n = in_data;
            hold_full_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign ser_valid = (state == SHIFT);
  assign ser_out   = ser_valid && sreg[OUT_BIT];
  assign ser_first = ser_valid && (cnt == '0);
  assign ser_last  = last_bit;
  assign busy      = (state == SHIFT) || hold_full;

endmodule
